clz_seq_unit: RTL

CLZ_SEQ_UNIT -- requirements
Module: clz_seq_unit

---
 rtl/clz_seq_unit_if.sv | 25 ++
 rtl/clz_seq_unit.sv | 112 +++++++++++
 2 files changed

// File: rtl/clz_seq_unit_if.sv
// Request/response bundle for the sequential leading-zero/one counter.
// The master drives the request; the slave (the counter) returns status and result.
interface clz_seq_unit_if #(
  parameter int unsigned WIDTH = 32
) ();
  localparam int unsigned RW = $clog2(WIDTH) + 1;

  logic             start;
  logic             mode;
  logic [WIDTH-1:0] operand;
  logic             flush;
  logic             busy;
  logic             done;
  logic [RW-1:0]    result;

  modport master (
    output start, mode, operand, flush,
    input  busy, done, result
  );

  modport slave (
    input  start, mode, operand, flush,
    output busy, done, result
  );
endinterface

// File: rtl/clz_seq_unit.sv
// Sequential leading-zero (or leading-one) counter: scans the operand STEP bits
// per cycle from the MSB and reports the count with a one-cycle done pulse.
module clz_seq_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned STEP  = 8
) (
  input  logic          clk,
  input  logic          reset,
  clz_seq_unit_if.slave bus
);
  localparam int unsigned RW     = $clog2(WIDTH) + 1;
  localparam int unsigned NCHUNK = WIDTH / STEP;
  localparam int unsigned KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  generate
    if ((WIDTH % STEP) != 0 || STEP > WIDTH || (STEP & (STEP - 1)) != 0) begin : g_bad_params
      $error("clz_seq_unit: STEP must be a power of two dividing WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_work;
  logic [KW-1:0]    r_k;
  logic [RW-1:0]    r_count;
  logic [RW-1:0]    r_result;
  logic             r_busy;
  logic             r_done;

  logic [STEP-1:0]  w_chunk;
  logic             w_zero;
  logic             w_last;
  logic [RW-1:0]    w_lz;

  // The working register shifts left once per chunk, so chunk k always sits at the top.
  assign w_chunk = r_work[WIDTH-1 -: STEP];
  assign w_zero  = ~|w_chunk;
  assign w_last  = (r_k == KW'(NCHUNK - 1));

  // Leading zeros inside the current chunk; the highest set bit wins.
  always_comb begin
    w_lz = RW'(STEP);
    for (int i = 0; i < int'(STEP); i++) begin
      if (w_chunk[i]) begin
        w_lz = RW'(int'(STEP) - 1 - i);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_work   <= '0;
      r_k      <= '0;
      r_count  <= '0;
      r_result <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (!bus.flush && bus.start) begin
            r_work  <= bus.mode ? ~bus.operand : bus.operand;
            r_k     <= '0;
            r_count <= '0;
            r_busy  <= 1'b1;
            r_state <= SCAN;
          end
        end
        SCAN: begin
          if (bus.flush) begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else if (!w_zero) begin
            r_result <= r_count + w_lz;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_state  <= DONE;
          end else if (w_last) begin
            r_result <= RW'(WIDTH);
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_state  <= DONE;
          end else begin
            r_count <= r_count + RW'(STEP);
            r_k     <= r_k + KW'(1);
            r_work  <= r_work << STEP;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign bus.result = r_result;
endmodule
